// File: rtl/acorn128_session_ctrl.sv
// acorn128_session_ctrl
// Buffers encrypt/decrypt jobs in a small request FIFO and runs them one at a
// time on a single ACORN-128 core.  Each job goes through a core reset, a launch,
// and a bounded wait for core_ready. The result is then held until the consumer
// accepts it.
// Optional feature macro: ACORN_TAG_CHECK_EN. When it is defined, decrypt jobs
// compare the core tag with the expected tag. On a mismatch the plaintext is
// replaced with zeros and res_auth_fail is raised.
module acorn128_session_ctrl #(
    parameter int FIFO_DEPTH      = 4,
    parameter int TIMEOUT         = 1024,
    parameter int CORE_RST_CYCLES = 2,
    parameter int ID_W            = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    // request side
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_decrypt,
    input  logic [127:0]    req_key,
    input  logic [127:0]    req_iv,
    input  logic [127:0]    req_text,
    input  logic [127:0]    req_ad,
    input  logic [63:0]     req_len,
    input  logic [127:0]    req_tag,
    input  logic [ID_W-1:0] req_id,
    // result side
    output logic            res_valid,
    input  logic            res_ready,
    output logic [127:0]    res_text,
    output logic [127:0]    res_tag,
    output logic [ID_W-1:0] res_id,
    output logic            res_auth_fail,
    output logic            res_timeout,
    // core side
    output logic            core_rst,
    output logic            core_start,
    output logic            core_encrypt,
    output logic [127:0]    core_key,
    output logic [127:0]    core_iv,
    output logic [127:0]    core_text,
    output logic [127:0]    core_ad,
    output logic [63:0]     core_len,
    input  logic [127:0]    core_text_out,
    input  logic [127:0]    core_tag,
    input  logic            core_ready,
    // status
    output logic            busy
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int TCNT_W = $clog2(TIMEOUT);
    localparam int RCNT_W = (CORE_RST_CYCLES > 1) ? $clog2(CORE_RST_CYCLES) : 1;

    localparam logic [CNT_W-1:0]  FIFO_FULL = CNT_W'(FIFO_DEPTH);
    localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT - 1);
    localparam logic [RCNT_W-1:0] RCNT_LOAD = RCNT_W'(CORE_RST_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CRST   = 3'd1,
        S_LAUNCH = 3'd2,
        S_WAIT   = 3'd3,
        S_RESULT = 3'd4
    } state_t;

    // ------------------------------------------------------------------
    // Request FIFO storage
    // ------------------------------------------------------------------
    logic              fifo_decrypt_r [FIFO_DEPTH];
    logic [127:0]      fifo_key_r     [FIFO_DEPTH];
    logic [127:0]      fifo_iv_r      [FIFO_DEPTH];
    logic [127:0]      fifo_text_r    [FIFO_DEPTH];
    logic [127:0]      fifo_ad_r      [FIFO_DEPTH];
    logic [63:0]       fifo_len_r     [FIFO_DEPTH];
    logic [ID_W-1:0]   fifo_id_r      [FIFO_DEPTH];
`ifdef ACORN_TAG_CHECK_EN
    logic [127:0]      fifo_tag_r     [FIFO_DEPTH];
`else
    logic              tag_unused_s;
`endif

    logic [PTR_W-1:0]  wr_ptr_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [CNT_W-1:0]  count_r;

    logic              full_s;
    logic              empty_s;
    logic              push_s;
    logic              pop_s;
    logic              tag_bad_s;

    // ------------------------------------------------------------------
    // Sequencer state and registered outputs
    // ------------------------------------------------------------------
    state_t            state_r;
    logic [RCNT_W-1:0] rst_cnt_r;
    logic [TCNT_W-1:0] tmo_cnt_r;
    logic              core_rst_r;
    logic              core_start_r;
    logic              res_valid_r;
    logic [127:0]      res_text_r;
    logic [127:0]      res_tag_r;
    logic [ID_W-1:0]   res_id_r;
    logic              res_auth_fail_r;
    logic              res_timeout_r;

    assign full_s    = (count_r == FIFO_FULL);
    assign empty_s   = (count_r == '0);
    assign req_ready = !full_s;
    assign push_s    = req_valid && !full_s;
    // The head entry leaves the FIFO only when its result is accepted.
    assign pop_s     = (state_r == S_RESULT) && res_valid_r && res_ready;

    // Core operands come straight from the head entry. The head does not change
    // while a job is in flight because the head is popped only at the result handshake.
    assign core_encrypt = !fifo_decrypt_r[rd_ptr_r];
    assign core_key     = fifo_key_r[rd_ptr_r];
    assign core_iv      = fifo_iv_r[rd_ptr_r];
    assign core_text    = fifo_text_r[rd_ptr_r];
    assign core_ad      = fifo_ad_r[rd_ptr_r];
    assign core_len     = fifo_len_r[rd_ptr_r];

`ifdef ACORN_TAG_CHECK_EN
    assign tag_bad_s = fifo_decrypt_r[rd_ptr_r] && (core_tag != fifo_tag_r[rd_ptr_r]);
`else
    assign tag_bad_s    = 1'b0;
    assign tag_unused_s = ^req_tag;
`endif

    assign core_rst      = core_rst_r;
    assign core_start    = core_start_r;
    assign res_valid     = res_valid_r;
    assign res_text      = res_text_r;
    assign res_tag       = res_tag_r;
    assign res_id        = res_id_r;
    assign res_auth_fail = res_auth_fail_r;
    assign res_timeout   = res_timeout_r;
    assign busy          = !empty_s || (state_r != S_IDLE);

    // Write accepted requests into the FIFO slot at the write pointer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_decrypt_r[i] <= 1'b0;
                fifo_key_r[i]     <= '0;
                fifo_iv_r[i]      <= '0;
                fifo_text_r[i]    <= '0;
                fifo_ad_r[i]      <= '0;
                fifo_len_r[i]     <= '0;
                fifo_id_r[i]      <= '0;
`ifdef ACORN_TAG_CHECK_EN
                fifo_tag_r[i]     <= '0;
`endif
            end
        end else if (push_s) begin
            fifo_decrypt_r[wr_ptr_r] <= req_decrypt;
            fifo_key_r[wr_ptr_r]     <= req_key;
            fifo_iv_r[wr_ptr_r]      <= req_iv;
            fifo_text_r[wr_ptr_r]    <= req_text;
            fifo_ad_r[wr_ptr_r]      <= req_ad;
            fifo_len_r[wr_ptr_r]     <= req_len;
            fifo_id_r[wr_ptr_r]      <= req_id;
`ifdef ACORN_TAG_CHECK_EN
            fifo_tag_r[wr_ptr_r]     <= req_tag;
`endif
        end
    end

    // FIFO pointers and occupancy; push and pop may happen on the same edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + 1'b1;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + 1'b1;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + 1'b1;
                2'b01:   count_r <= count_r - 1'b1;
                default: count_r <= count_r;
            endcase
        end
    end

    // Job sequencer: core reset, launch, bounded wait for ready, result hold
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r         <= S_IDLE;
            rst_cnt_r       <= '0;
            tmo_cnt_r       <= '0;
            core_rst_r      <= 1'b1;
            core_start_r    <= 1'b0;
            res_valid_r     <= 1'b0;
            res_text_r      <= '0;
            res_tag_r       <= '0;
            res_id_r        <= '0;
            res_auth_fail_r <= 1'b0;
            res_timeout_r   <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    core_start_r <= 1'b0;
                    if (!empty_s) begin
                        state_r    <= S_CRST;
                        rst_cnt_r  <= RCNT_LOAD;
                        core_rst_r <= 1'b1;
                    end else begin
                        core_rst_r <= 1'b0;
                    end
                end
                S_CRST: begin
                    // The counter is loaded with CORE_RST_CYCLES-1. This keeps
                    // core_rst high for exactly CORE_RST_CYCLES cycles.
                    if (rst_cnt_r == '0) begin
                        state_r      <= S_LAUNCH;
                        core_rst_r   <= 1'b0;
                        core_start_r <= 1'b1;
                    end else begin
                        rst_cnt_r <= rst_cnt_r - 1'b1;
                    end
                end
                S_LAUNCH: begin
                    state_r   <= S_WAIT;
                    tmo_cnt_r <= '0;
                end
                S_WAIT: begin
                    // If core_ready arrives on the same edge as the last
                    // timeout count, core_ready wins and the result is normal.
                    if (core_ready) begin
                        state_r         <= S_RESULT;
                        core_start_r    <= 1'b0;
                        res_valid_r     <= 1'b1;
                        res_text_r      <= tag_bad_s ? 128'd0 : core_text_out;
                        res_tag_r       <= core_tag;
                        res_id_r        <= fifo_id_r[rd_ptr_r];
                        res_auth_fail_r <= tag_bad_s;
                        res_timeout_r   <= 1'b0;
                    end else if (tmo_cnt_r == TCNT_LAST) begin
                        state_r         <= S_RESULT;
                        core_start_r    <= 1'b0;
                        res_valid_r     <= 1'b1;
                        res_text_r      <= '0;
                        res_tag_r       <= '0;
                        res_id_r        <= fifo_id_r[rd_ptr_r];
                        res_auth_fail_r <= 1'b0;
                        res_timeout_r   <= 1'b1;
                    end else begin
                        tmo_cnt_r <= tmo_cnt_r + 1'b1;
                    end
                end
                S_RESULT: begin
                    if (res_ready) begin
                        state_r     <= S_IDLE;
                        res_valid_r <= 1'b0;
                    end
                end
                default: begin
                    state_r      <= S_IDLE;
                    core_rst_r   <= 1'b1;
                    core_start_r <= 1'b0;
                    res_valid_r  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/acorn128_session_ctrl.md
# acorn128_session_ctrl

Job sequencer for the ACORN-128 core (`acorn128_top`) that replaces hand-driven start/reset/wait sequencing with a buffered request/response interface. It queues up to `FIFO_DEPTH` encrypt/decrypt jobs and runs them one at a time on a single core instance, resetting the core between jobs. It adds two behaviours the bare core lacks: a per-job ready timeout and optional decrypt tag verification with plaintext masking. It sits between the system bus adapter and the core.

## Interface
- `FIFO_DEPTH`, 4: request FIFO entries; power of two, ≥2.
- `TIMEOUT`, 1024: maximum cycles spent waiting for `core_ready`; ≥2.
- `CORE_RST_CYCLES`, 2: cycles `core_rst` is held high before each job; ≥1.
- `ID_W`, 4: job tag width.

Ports:
- `clk` in 1: sole clock, all logic on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in 1, `req_ready` out 1: request handshake.
- `req_decrypt` in 1: 0 = encrypt, 1 = decrypt.
- `req_key`, `req_iv`, `req_text`, `req_ad` in 128 each: job operands.
- `req_len` in 64: data length, forwarded to the core.
- `req_tag` in 128: expected tag; used only for decrypt.
- `req_id` in `ID_W`: job tag, returned with the result.
- `res_valid` out 1, `res_ready` in 1: result handshake.
- `res_text` out 128, `res_tag` out 128, `res_id` out `ID_W`: result payload.
- `res_auth_fail` out 1, `res_timeout` out 1: result status.
- `core_rst` out 1: active-high core reset.
- `core_start` out 1, `core_encrypt` out 1: core control.
- `core_key`, `core_iv`, `core_text`, `core_ad` out 128; `core_len` out 64: operands to the core.
- `core_text_out` in 128, `core_tag` in 128, `core_ready` in 1: core results.
- `busy` out 1: FIFO non-empty or FSM not in IDLE.

## Operation
- **Request FIFO:** stores `{decrypt,key,iv,text,ad,len,tag,id}`.
  - `req_ready = !full`, combinational.
  - A push happens on any edge with `req_valid && req_ready`.
  - Pop happens only on the result handshake, so push and pop may coincide.
- **Core operands:** `core_key/iv/text/ad/len` are driven combinationally from the FIFO head and are stable for the whole job. `core_encrypt = !head.decrypt`.
- **FSM (one-hot or encoded, designer's choice):**
  - **IDLE:** if the FIFO is non-empty → CRST, load the reset counter.
  - **CRST:** `core_rst=1` for exactly `CORE_RST_CYCLES` cycles → LAUNCH.
  - **LAUNCH:** `core_rst=0`, `core_start=1`, clear the timeout counter → WAIT.
  - **WAIT:** `core_start=1`; counter increments each cycle.
    - If `core_ready` is sampled high → RESULT, capturing `core_text_out`/`core_tag`.
    - Otherwise, if counter == `TIMEOUT-1` → RESULT with timeout.
    - `core_ready` wins if both occur at the same edge.
  - **RESULT:** `core_start=0`, `res_valid=1`, payload held stable until `res_valid && res_ready`; then pop → IDLE.
- **Normal result:** `res_text=core_text_out`, `res_tag=core_tag`, `res_auth_fail=0`, `res_timeout=0`.
- **Timeout result:** `res_text=0`, `res_tag=0`, `res_timeout=1`, `res_auth_fail=0`.
- **Decrypt result:** tag check applies, see Configuration.
- **Ordering:** results are returned strictly in request order.
- **Reset mid-operation:** the FIFO is emptied, the FSM goes to IDLE, and `core_rst` asserts immediately. In-flight jobs are dropped with no result.
- `core_ready` is ignored outside WAIT.

## Timing
- **Reset values:**
  - `req_ready=1` (FIFO empty).
  - `core_rst=1` (core held in reset).
  - `res_valid`, `res_auth_fail`, `res_timeout`, `core_start`, `busy` = 0.
  - `res_text`, `res_tag`, `res_id` = 0.
- **Push at edge E0 into an empty, idle block:**
  - E1 enters CRST.
  - `core_rst` is high for cycles E1..E(`CORE_RST_CYCLES`).
  - `core_start` first goes high in the cycle after the last CRST cycle.
- **Result latency:** `res_valid` rises the cycle after the edge at which `core_ready` is sampled high in WAIT.
- **Timeout:** WAIT lasts exactly `TIMEOUT` cycles.
- **Back-to-back jobs:** the next job's CRST begins the cycle after the pop edge.
- **Widths:** the timeout counter is `$clog2(TIMEOUT)` bits and does not wrap; it is cleared in LAUNCH.

## Configuration
- Macro: `ACORN_TAG_CHECK_EN`.
- **Defined:** for a decrypt job with `core_tag != head.tag`:
  - `res_auth_fail=1` and `res_text=0`;
  - `res_tag` still returns `core_tag`.
  - On a match, `res_auth_fail=0` and the text passes through.
- **Undefined:** `res_auth_fail` is constant 0; decrypt text always passes through; `req_tag` is not stored in the FIFO.

## Test plan
- **Reset:** assert `rst_n=0` mid-WAIT with 2 jobs queued.
  - Required: `core_rst=1` immediately, `res_valid=0`, `busy=0`, `req_ready=1` after release.
  - No stale result appears for the dropped jobs.
- **Encrypt:** core model raises `core_ready` 40 cycles after `core_start`, with `core_text_out=128'hA5..A5` and `core_tag=128'h1234..`.
  - Required: `res_valid` carries exactly those values, `res_id` matches, both flags 0.
  - `core_rst` is high for exactly 2 cycles before `core_start`.
- **Decrypt (macro on):**
  - Match with `req_tag=core_tag` → `res_auth_fail=0`, text passes through.
  - Mismatch (1 bit flipped) → `res_auth_fail=1`, `res_text=0`.
  - Rerun with the macro off → mismatch yields `res_auth_fail=0`, text passes through.
- **Queue full and backpressure:** `FIFO_DEPTH=4`, push ids 0..3 back-to-back.
  - Required: `req_ready=0` after the 4th push.
  - Results return in order 0,1,2,3.
  - Holding `res_ready=0` for 10 cycles keeps the payload stable.
  - A push in the same cycle as a pop is accepted.
- **Timeout:** `TIMEOUT=64`, core never ready.
  - Required: `res_timeout=1` with `res_text=0` and `res_tag=0`, `res_valid` rising 64 WAIT cycles after LAUNCH.
  - The next queued job then runs normally.
- **Boundary:** `core_ready` rises on the same edge the counter reaches `TIMEOUT-1`.
  - Required: normal result, `res_timeout=0`.
